// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty flags and a read-valid strobe.
// Optional sticky overflow/underflow flags with clearErr are enabled by defining FIFO_ERR_FLAGS_EN.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int AF_THRESH  = 28,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] datain,
    input  logic                  read,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic                  clearErr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  dataValid,
    output logic                  full,
    output logic                  empty,
    output logic                  almostFull,
    output logic                  almostEmpty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_LVL = PTR_W'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_LVL = PTR_W'(AE_THRESH);

`ifndef SYNTHESIS
    initial begin
        if (AF_THRESH < 1 || AF_THRESH > DEPTH)
            $error("fifo_sync_param: AF_THRESH=%0d outside 1..%0d", AF_THRESH, DEPTH);
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1)
            $error("fifo_sync_param: AE_THRESH=%0d outside 0..%0d", AE_THRESH, DEPTH - 1);
    end
`endif

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;
    logic                  write_en;
    logic                  read_en;
    logic                  ptr_low_eq;

    // Status depends only on registered pointers; the MSB is the wrap bit.
    assign ptr_low_eq  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign full        = ptr_low_eq & (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    assign empty       = ptr_low_eq & (wr_ptr_q[ADDR_WIDTH] == rd_ptr_q[ADDR_WIDTH]);
    assign count       = wr_ptr_q - rd_ptr_q;
    assign almostFull  = (count >= AF_LVL);
    assign almostEmpty = (count <= AE_LVL);
    assign dataout     = dout_q;
    assign dataValid   = valid_q;

    always_comb begin
        write_en = write & ~full;
        read_en  = read & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (write_en)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (read_en)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= read_en;
            if (read_en)
                dout_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    // Storage is left unreset so it can map onto block RAM.
    always_ff @(posedge clock) begin
        if (write_en)
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= datain;
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error in the same cycle as clearErr keeps the flag set.
    always_comb begin
        overflow_d  = (overflow_q & ~clearErr) | (write & full);
        underflow_d = (underflow_q & ~clearErr) | (read & empty);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param (8-deep, AF=6, AE=2): queue model checked every cycle plus directed literal checks.
module tb_fifo_sync_param;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          write = 1'b0;
    logic          read  = 1'b0;
    logic [DW-1:0] datain = '0;
    logic [DW-1:0] dataout;
    logic          dataValid, full, empty, almostFull, almostEmpty;
    logic [AW:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
    logic clearErr = 1'b0;
    logic overflow, underflow;
`endif

    int n_vec = 0;
    int n_bad = 0;

    fifo_sync_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clock(clock), .reset(reset), .write(write), .datain(datain), .read(read),
`ifdef FIFO_ERR_FLAGS_EN
        .clearErr(clearErr), .overflow(overflow), .underflow(underflow),
`endif
        .dataout(dataout), .dataValid(dataValid), .full(full), .empty(empty),
        .almostFull(almostFull), .almostEmpty(almostEmpty), .count(count)
    );

    always #5 clock = ~clock;

    // Reference model: contents as a queue, read register as plain variables.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    logic          m_valid;
`ifdef FIFO_ERR_FLAGS_EN
    logic m_ovf, m_unf;
`endif

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_dout  <= '0;
            m_valid <= 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
`endif
        end else begin
            bit wen, ren;
            wen = write && (mq.size() < DEPTH);
            ren = read && (mq.size() > 0);
`ifdef FIFO_ERR_FLAGS_EN
            m_ovf <= (write && mq.size() == DEPTH) ? 1'b1 : (clearErr ? 1'b0 : m_ovf);
            m_unf <= (read && mq.size() == 0) ? 1'b1 : (clearErr ? 1'b0 : m_unf);
`endif
            m_valid <= ren;
            if (ren)
                m_dout <= mq.pop_front();
            if (wen)
                mq.push_back(datain);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        int sz;
        sz = mq.size();
        chk("count", int'(count), sz);
        chk("empty", int'(empty), int'(sz == 0));
        chk("full", int'(full), int'(sz == DEPTH));
        chk("almostFull", int'(almostFull), int'(sz >= AF));
        chk("almostEmpty", int'(almostEmpty), int'(sz <= AE));
        chk("dataout", int'(dataout), int'(m_dout));
        chk("dataValid", int'(dataValid), int'(m_valid));
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_unf));
`endif
        $display("cyc t=%0t w=%0b r=%0b din=%02h cnt=%0d dout=%02h v=%0b", $time, write, read, datain,
                 count, dataout, dataValid);
    end

    // Drive one cycle of inputs, return 1ns after the following falling edge.
    task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d);
        write  = w;
        read   = r;
        datain = d;
        @(posedge clock);
        @(negedge clock);
        #1;
        write = 1'b0;
        read  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
        cycle(0, 0, 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_ae", int'(almostEmpty), 1);
        chk("rst_dout", int'(dataout), 0);
        chk("rst_valid", int'(dataValid), 0);

        for (int i = 1; i <= 8; i++) begin
            cycle(1, 0, DW'(i));
            chk("fill_count", int'(count), i);
            chk("fill_af", int'(almostFull), int'(i >= 6));
        end
        chk("fill_full", int'(full), 1);
        cycle(1, 0, 8'hAA);
        chk("ovf_count", int'(count), 8);
`ifdef FIFO_ERR_FLAGS_EN
        chk("ovf_flag", int'(overflow), 1);
        clearErr = 1'b1;
        cycle(0, 0, 0);
        clearErr = 1'b0;
        chk("ovf_clear", int'(overflow), 0);
`endif
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 1, 0);
            chk("drain_dout", int'(dataout), i);
            chk("drain_valid", int'(dataValid), 1);
        end
        chk("drain_empty", int'(empty), 1);

        cycle(1, 1, 8'h55);
        chk("wr_rd_empty_count", int'(count), 1);
        chk("wr_rd_empty_valid", int'(dataValid), 0);
        cycle(0, 1, 0);
        chk("nofall_dout", int'(dataout), 8'h55);
        chk("nofall_valid", int'(dataValid), 1);

        for (int i = 0; i < 3; i++)
            cycle(1, 0, DW'(8'h20 + i));
        for (int i = 0; i < 40; i++) begin
            cycle(1, 1, DW'(8'h30 + i));
            chk("stream_count", int'(count), 3);
            chk("stream_dout", int'(dataout), (i < 3) ? (8'h20 + i) : (8'h30 + i - 3));
        end
        repeat (3) cycle(0, 1, 0);
        chk("stream_empty", int'(empty), 1);

        for (int i = 0; i < 5; i++)
            cycle(1, 0, DW'(8'hC0 + i));
        chk("pre_rst_count", int'(count), 5);
        #1 reset = 1'b1;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_empty", int'(empty), 1);
        chk("async_full", int'(full), 0);
        chk("async_ae", int'(almostEmpty), 1);
        chk("async_dout", int'(dataout), 0);
        chk("async_valid", int'(dataValid), 0);
        @(negedge clock);
        #1 reset = 1'b0;
        cycle(1, 0, 8'h3C);
        cycle(0, 1, 0);
        chk("post_rst_dout", int'(dataout), 8'h3C);
        chk("post_rst_valid", int'(dataValid), 1);

        for (int i = 0; i < 400; i++) begin
            int wb;
            wb = (i < 200) ? 70 : 30;
`ifdef FIFO_ERR_FLAGS_EN
            clearErr = ($urandom_range(0, 99) < 10);
`endif
            cycle($urandom_range(0, 99) < wb, $urandom_range(0, 99) < (100 - wb),
                  DW'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised successor to the fixed 32x8 synchronous FIFO, with configurable data width and depth. Adds an asynchronous reset, an occupancy count, almost-full/almost-empty thresholds and a registered read-data valid strobe. Used as the general buffering primitive between producer and consumer blocks that share one clock domain.

Parameters:
DATA_WIDTH, 8, width of datain/dataout in bits (>=1)
ADDR_WIDTH, 5, log2 of depth; DEPTH = 2**ADDR_WIDTH entries (>=1)
AF_THRESH, 28, almostFull asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 4, almostEmpty asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
clock  input  1  single clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
write  input  1  write request
datain  input  DATA_WIDTH  write data, sampled on an accepted write
read  input  1  read request
dataout  output  DATA_WIDTH  registered read data
dataValid  output  1  high for one cycle when dataout carries a newly read word
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
almostFull  output  1  count >= AF_THRESH
almostEmpty  output  1  count <= AE_THRESH
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Pointers: writePtr and readPtr are each ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address the memory; the MSB is the wrap (round) bit.
- full = (MSBs differ) & (low bits equal).
- empty = (MSBs equal) & (low bits equal).
- count = writePtr - readPtr, modulo 2**(ADDR_WIDTH+1).
- full, empty, count, almostFull and almostEmpty are combinational from the registered pointers only, never from write/read.
- Acceptance: writeEn = write & ~full; readEn = read & ~empty. Both are evaluated against the pre-edge state.
- Accepted write: mem[writePtr low bits] <= datain; writePtr increments by 1.
- Accepted read: dataout <= mem[readPtr low bits]; readPtr increments by 1; dataValid <= 1.
- Read latency: data appears on dataout one cycle after the accepted read edge.
- No accepted read: dataout holds its previous value and dataValid <= 0.
- Rejected requests (write when full, read when empty) are ignored with no side effects.
- Simultaneous write and read, not full and not empty: both are accepted and count is unchanged.
- Simultaneous write and read when empty: only the write is accepted and count becomes 1. There is no fall-through; the word is read on a later cycle.
- Simultaneous write and read when full: only the read is accepted and count becomes DEPTH-1.
- Wrap-around: pointers roll over naturally at 2**(ADDR_WIDTH+1). Full/empty detection stays correct across unlimited wraps.
- Reset (at any time, including mid-transfer):
  - writePtr = readPtr = 0; dataout = 0; dataValid = 0.
  - Resulting outputs: empty = 1, full = 0, count = 0, almostEmpty = 1, almostFull = 0 (when AF_THRESH >= 1).
  - Memory contents are not reset and are unobservable until rewritten.
- Parameter legality: an illegal AF_THRESH or AE_THRESH is flagged by a simulation-time $error in an initial block.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds input clearErr (1 bit) and outputs overflow (1 bit) and underflow (1 bit).
  - overflow is set on the edge after a write while full; underflow is set on the edge after a read while empty.
  - Both flags are sticky until clearErr = 1 or reset.
  - If clearErr and a new error occur in the same cycle, the set wins.
  - Both flags reset to 0.
- Undefined: these ports and their logic are absent, and rejected requests remain silent.

Test Plan:
- Reset then idle (ADDR_WIDTH=3, AF=6, AE=2) -> empty=1, full=0, count=0, almostEmpty=1, dataout=0, dataValid=0.
- Write 0x01..0x08 on 8 cycles, then read 8 cycles -> almostFull rises at count=6, full at 8; dataout = 0x01..0x08 in order, each one cycle after its read edge, with dataValid high for 8 cycles; ends with empty=1.
- At full, assert write=1 with datain=0xAA -> count stays 8 and 0xAA is never read. With FIFO_ERR_FLAGS_EN, overflow=1 until clearErr.
- At empty, assert write and read together with datain=0x55 -> count=1, dataValid=0. On the next read, dataout=0x55.
- Stream 40 words with write and read continuous after 3 pre-fills -> count stays at 3, pointers wrap at least twice, and the data sequence is intact.
- Assert reset mid-stream at count=5 -> outputs take their reset values immediately (asynchronous, before the next clock edge). A subsequent write/read of 0x3C returns 0x3C.
